alu_decoder: RTL and testbench

ALU_DECODER -- requirements
Module: alu_decoder

---
 rtl/alu_decoder.sv | 88 ++++++++
 tb/tb_alu_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// +----------------------------------------------------------------------------+
// | alu_decoder: registered RISC-V ALU control decoder (funct3/funct7/ALUOp).   |
// | Optional macro ALU_DECODER_ILLEGAL_EN enables undefined-encoding detection. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_decoder #(
  parameter logic [3:0] RESET_CTRL = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLTU = 4'b0110;
  localparam logic [3:0] C_SLL  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;

  logic [3:0] ctrl_next;

  always_comb begin
    ctrl_next = C_ADD;
    case (ALUOp)
      2'b00: ctrl_next = C_ADD;
      2'b01: ctrl_next = C_SUB;
      default: begin
        case (funct3)
          // Only R-type (ALUOp=10) can select SUB; immediates always add.
          3'b000:  ctrl_next = (!ALUOp[0] && opb5 && funct7b5) ? C_SUB : C_ADD;
          3'b001:  ctrl_next = C_SLL;
          3'b010:  ctrl_next = C_SLT;
          3'b011:  ctrl_next = C_SLTU;
          3'b100:  ctrl_next = C_XOR;
          3'b101:  ctrl_next = funct7b5 ? C_SRA : C_SRL;
          3'b110:  ctrl_next = C_OR;
          default: ctrl_next = C_AND;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUControl <= RESET_CTRL;
    end else if (en) begin
      ALUControl <= ctrl_next;
    end
  end

`ifdef ALU_DECODER_ILLEGAL_EN
  logic illegal_next;

  always_comb begin
    illegal_next = 1'b0;
    if (ALUOp == 2'b10 && opb5 && funct7b5 && funct3 != 3'b000 && funct3 != 3'b101)
      illegal_next = 1'b1;
    if (ALUOp == 2'b11 && funct7b5 && funct3 == 3'b001)
      illegal_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (en) begin
      illegal <= illegal_next;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_alu_decoder: directed vector bench for alu_decoder.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_decoder;

`ifdef ALU_DECODER_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       opb5;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [1:0] ALUOp;
  logic [3:0] ALUControl;
  logic       illegal;

  int n_cmp;
  int n_bad;

  alu_decoder #(.RESET_CTRL(4'b0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .opb5       (opb5),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (ALUOp),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop;
    logic       b5;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] exp_ctrl;
    logic       exp_ill;   // expectation when detection is compiled in
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [3:0] ctrl_req, input logic ill_req);
    n_cmp++;
    if (ALUControl !== ctrl_req || illegal !== ill_req) begin
      n_bad++;
      $display("FAIL %s: got ctrl=%b illegal=%b, want ctrl=%b illegal=%b",
               name, ALUControl, illegal, ctrl_req, ill_req);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic b, input logic [2:0] f, input logic f7);
    ALUOp = a; opb5 = b; funct3 = f; funct7b5 = f7;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{2'b00, 1'b1, 3'b000, 1'b1, 4'b0000, 1'b0};
    vecs[1]  = '{2'b10, 1'b0, 3'b010, 1'b0, 4'b0101, 1'b0};
    vecs[2]  = '{2'b10, 1'b1, 3'b000, 1'b1, 4'b0001, 1'b0};
    vecs[3]  = '{2'b10, 1'b0, 3'b000, 1'b1, 4'b0000, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, 3'b001, 1'b0, 4'b0111, 1'b0};
    vecs[5]  = '{2'b11, 1'b0, 3'b101, 1'b1, 4'b1001, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 3'b111, 1'b0, 4'b0010, 1'b0};
    vecs[7]  = '{2'b10, 1'b0, 3'b110, 1'b0, 4'b0011, 1'b0};
    vecs[8]  = '{2'b10, 1'b1, 3'b001, 1'b0, 4'b0111, 1'b0};
    vecs[9]  = '{2'b10, 1'b0, 3'b011, 1'b0, 4'b0110, 1'b0};
    vecs[10] = '{2'b10, 1'b0, 3'b100, 1'b0, 4'b0100, 1'b0};
    vecs[11] = '{2'b10, 1'b0, 3'b101, 1'b0, 4'b1000, 1'b0};
    vecs[12] = '{2'b11, 1'b1, 3'b000, 1'b1, 4'b0000, 1'b0};
    vecs[13] = '{2'b01, 1'b1, 3'b111, 1'b1, 4'b0001, 1'b0};
    vecs[14] = '{2'b10, 1'b1, 3'b111, 1'b1, 4'b0010, 1'b1};
    vecs[15] = '{2'b11, 1'b0, 3'b001, 1'b1, 4'b0111, 1'b1};
    vecs[16] = '{2'b10, 1'b1, 3'b101, 1'b1, 4'b1001, 1'b0};
    vecs[17] = '{2'b10, 1'b0, 3'b111, 1'b1, 4'b0010, 1'b0};
    vecs[18] = '{2'b11, 1'b1, 3'b010, 1'b1, 4'b0101, 1'b0};

    // Reset with enable high and clock running: register must not move.
    rst_n = 1'b0;
    en = 1'b1;
    drive(2'b10, 1'b1, 3'b111, 1'b1);
    #2;
    check("reset_state", 4'b0000, 1'b0);
    tick();
    tick();
    check("reset_hold_with_clk", 4'b0000, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].aluop, vecs[i].b5, vecs[i].f3, vecs[i].f7);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_ill & ILL_EN);
    end

    // Enable low: outputs hold for several cycles, then update on re-enable.
    @(negedge clk);
    drive(2'b10, 1'b0, 3'b110, 1'b0);
    tick();
    check("hold_load_or", 4'b0011, 1'b0);
    @(negedge clk);
    en = 1'b0;
    drive(2'b01, 1'b0, 3'b000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("hold_cycle%0d", c), 4'b0011, 1'b0);
    end
    @(negedge clk);
    en = 1'b1;
    tick();
    check("hold_release_sub", 4'b0001, 1'b0);

    // Illegal flag also holds while disabled.
    @(negedge clk);
    drive(2'b10, 1'b1, 3'b111, 1'b1);
    tick();
    check("ill_load", 4'b0010, ILL_EN);
    @(negedge clk);
    en = 1'b0;
    drive(2'b00, 1'b0, 3'b000, 1'b0);
    tick();
    check("ill_hold", 4'b0010, ILL_EN);
    @(negedge clk);
    en = 1'b1;
    tick();
    check("ill_clear", 4'b0000, 1'b0);

    // Asynchronous reset mid-cycle takes effect before the next edge.
    @(negedge clk);
    drive(2'b10, 1'b0, 3'b001, 1'b0);
    tick();
    check("pre_async_sll", 4'b0111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 1'b0);
    tick();
    check("reset_wins_edge", 4'b0000, 1'b0);

    // First update after release on first enabled edge.
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    check("post_reset_disabled", 4'b0000, 1'b0);
    @(negedge clk);
    en = 1'b1;
    tick();
    check("post_reset_first_update", 4'b0111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
